// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter run scheduler.
package counter_sched_pkg;
  localparam int WIDTH_DEFAULT = 5;
  localparam int FIELD_VEC_W   = 128;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_state_e;

  // Requester i's w-bit field from a packed vector; caller zero-extends to FIELD_VEC_W.
  function automatic logic [31:0] get_field(input logic [FIELD_VEC_W-1:0] vec,
                                            input int i, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (i * w)) & mask;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         pick,
  output logic                    valid
);
  logic [NREQ-1:0]   rot, rot_pick;
  logic [2*NREQ-1:0] pick_dbl;

  // Rotate so bit 0 is the requester at ptr, take the lowest set bit, rotate back.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    rot_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rot_pick    = '0;
        rot_pick[k] = 1'b1;
      end
    end
  end

  assign pick_dbl = {{NREQ{1'b0}}, rot_pick} << ptr;
  assign pick     = pick_dbl[NREQ-1:0] | pick_dbl[2*NREQ-1:NREQ];
  assign valid    = |req;
endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one WIDTH-bit counter among NREQ requesters:
// each run preloads the counter, advances it len ticks, and cross-checks the final count.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_start,
  input  logic [NREQ*WIDTH-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  err,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_load_val,
  output logic                  cnt_en,
  input  logic [WIDTH-1:0]      cnt_value
);
  localparam int PW = $clog2(NREQ);

  sched_state_e    state;
  logic [PW-1:0]   ptr, pick_idx;
  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic [WIDTH-1:0] start_q, len_q, remaining, pick_start, pick_len;
  logic            held;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign pick_start = WIDTH'(get_field(FIELD_VEC_W'(req_start), int'(pick_idx), WIDTH));
  assign pick_len   = WIDTH'(get_field(FIELD_VEC_W'(req_len),   int'(pick_idx), WIDTH));

  // gnt is the one-hot latch of the granted index, so this is req[g].
  assign held = |(req & gnt);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      start_q      <= '0;
      len_q        <= '0;
      remaining    <= '0;
      gnt          <= '0;
      done         <= '0;
      result       <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_en       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            start_q      <= pick_start;
            len_q        <= pick_len;
            gnt          <= pick;
            ptr          <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt_load     <= 1'b1;
            cnt_load_val <= pick_start;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          cnt_load  <= 1'b0;
          remaining <= len_q;
          result    <= start_q + len_q;
          if (!held) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (len_q != '0) begin
            cnt_en <= 1'b1;
            state  <= RUN;
          end else begin
            done  <= gnt;
            state <= DONE;
          end
        end
        RUN: begin
          remaining <= remaining - 1'b1;
          if (!held) begin
            gnt    <= '0;
            busy   <= 1'b0;
            cnt_en <= 1'b0;
            state  <= IDLE;
          end else if (remaining == WIDTH'(1)) begin
            cnt_en <= 1'b0;
            done   <= gnt;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
          if (cnt_value != result) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: harness counter, cycle-index reference model, directed and random runs.
module tb_counter_sched;
  localparam int W = 5;
  localparam int N = 2;
  localparam int M = 1 << W;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_start = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result, cnt_load_val, cnt_value, cnt_q;
  logic           busy, err, cnt_load, cnt_en;
  logic           corrupt = 1'b0;
  logic           chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_start    (req_start),
    .req_len      (req_len),
    .gnt          (gnt),
    .done         (done),
    .result       (result),
    .busy         (busy),
    .err          (err),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_value    (cnt_value)
  );

  // Harness counter following the load/enable contract; corrupt skews it during done.
  always @(posedge clk)
    if (!reset_n)      cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_en)   cnt_q <= cnt_q + 1'b1;
  assign cnt_value = cnt_q + ((corrupt && done != '0) ? W'(1) : W'(0));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since the grant edge; done lands in cycle d.
  bit m_act, m_rst, m_err, found;
  int m_g, m_st, m_ln, m_k, m_ptr, m_res, c;

  function automatic int exp_d();
    return (m_ln == 0) ? 2 : m_ln + 2;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_act = 0; m_rst = 1; m_err = 0; m_ptr = 0; m_res = 0; m_k = 0;
    end else begin
      m_rst = 0;
      if (!m_act) begin
        found = 0;
        for (int o = 0; o < N; o++) begin
          c = (m_ptr + o) % N;
          if (!found && req[c]) begin found = 1; m_g = c; end
        end
        if (found) begin
          m_st  = int'(req_start[m_g*W +: W]);
          m_ln  = int'(req_len[m_g*W +: W]);
          m_act = 1;
          m_k   = 1;
          m_ptr = (m_g + 1) % N;
        end
      end else begin
        if (m_k == 1) m_res = (m_st + m_ln) % M;
        if (m_k == exp_d()) begin
          if (int'(cnt_value) != m_res) m_err = 1;
          m_act = 0;
        end else if (!req[m_g]) m_act = 0;
        else m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",    int'(gnt),  m_act ? (1 << m_g) : 0);
      check("done",   int'(done), (m_act && m_k == exp_d()) ? (1 << m_g) : 0);
      check("busy",   int'(busy), int'(m_act));
      check("load",   int'(cnt_load), int'(m_act && m_k == 1));
      check("en",     int'(cnt_en), int'(m_act && m_k >= 2 && m_k < exp_d()));
      check("result", int'(result), m_res);
      check("err",    int'(err), int'(m_err));
      if (m_act && m_k == 1) check("load_val", int'(cnt_load_val), m_st);
      if (m_rst)             check("load_val_rst", int'(cnt_load_val), 0);
      if (m_act && m_k == exp_d() && !corrupt) check("cnt_final", int'(cnt_value), m_res);
    end
  end

  // Directed-run capture
  int r_loads, r_ens, r_dcy, r_done, r_res, r_cnt, r_gnt1, r_err;
  int seq [0:31];
  int exp_seq [6] = '{30, 31, 0, 1, 2, 3};
  int g_cyc [4], g_val [4], d_cyc [4], d_val [4];
  int ng, nd;
  logic [N-1:0] prev_gnt;

  task automatic run_one(input int i, input int st, input int ln, input int ncyc);
    @(negedge clk);
    req_start[i*W +: W] = W'(st);
    req_len[i*W +: W]   = W'(ln);
    req    = '0;
    req[i] = 1'b1;
    r_loads = 0; r_ens = 0; r_dcy = 0; r_done = 0; r_res = 0; r_cnt = 0; r_gnt1 = 0; r_err = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) r_gnt1 = int'(gnt);
      seq[n] = int'(cnt_value);
      if (cnt_load) r_loads++;
      if (cnt_en)   r_ens++;
      if (done != '0) begin
        r_dcy = n; r_done = int'(done); r_res = int'(result);
        r_cnt = int'(cnt_value); r_err = int'(err);
        req = '0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    check("rst_load_val", int'(cnt_load_val), 0);
    reset_n = 1'b1;

    // Single run
    run_one(0, 3, 4, 8);
    check("t1_gnt", r_gnt1, 1);
    check("t1_loads", r_loads, 1);
    check("t1_ens", r_ens, 4);
    check("t1_done_cycle", r_dcy, 6);
    check("t1_done", r_done, 1);
    check("t1_result", r_res, 7);
    check("t1_cnt", r_cnt, 7);
    check("t1_err", r_err, 0);

    // Zero length
    run_one(1, 9, 0, 5);
    check("t2_done_cycle", r_dcy, 2);
    check("t2_done", r_done, 2);
    check("t2_result", r_res, 9);
    check("t2_ens", r_ens, 0);

    // Wrap-around
    run_one(0, 30, 5, 9);
    check("t3_result", r_res, 3);
    check("t3_done_cycle", r_dcy, 7);
    check("t3_err", r_err, 0);
    for (int n = 0; n < 6; n++) check("t3_seq", seq[n+2], exp_seq[n]);

    // Fairness
    do_reset();
    req_start = {W'(4), W'(8)};
    req_len   = {W'(1), W'(1)};
    req       = 2'b11;
    ng = 0; nd = 0; prev_gnt = '0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (gnt != '0 && prev_gnt == '0 && ng < 4) begin g_cyc[ng] = n; g_val[ng] = int'(gnt); ng++; end
      if (done != '0 && nd < 4) begin d_cyc[nd] = n; d_val[nd] = int'(done); nd++; end
      prev_gnt = gnt;
      if (n == 16) req = '0;
    end
    check("t4_ngrants", ng, 4);
    check("t4_ndone", nd, 4);
    for (int j = 0; j < 4; j++) begin
      check("t4_gnt_cycle", g_cyc[j], 1 + 4*j);
      check("t4_gnt_val", g_val[j], (j % 2 == 0) ? 1 : 2);
      check("t4_done_cycle", d_cyc[j], 3 + 4*j);
      check("t4_done_val", d_val[j], g_val[j]);
    end

    // Abort in second RUN cycle
    @(negedge clk);
    req_start[0 +: W] = W'(2);
    req_len[0 +: W]   = W'(6);
    req = 2'b01;
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);
    check("t5_abort_gnt", int'(gnt), 0);
    check("t5_abort_busy", int'(busy), 0);
    r_done = 0;
    repeat (5) begin
      if (done != '0) r_done++;
      @(negedge clk);
    end
    check("t5_no_done", r_done, 0);
    req = 2'b01;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_gnt", int'(gnt), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_done", int'(done), 0);
    check("t5_rst_en", int'(cnt_en), 0);
    check("t5_rst_result", int'(result), 0);
    reset_n = 1'b1;
    req = 2'b11;
    @(negedge clk);
    check("t5_ptr_reset", int'(gnt), 1);
    req = '0;
    repeat (3) @(negedge clk);

    // Checker
    corrupt = 1'b1;
    run_one(0, 5, 2, 6);
    check("t6_done_cycle", r_dcy, 4);
    check("t6_err_set", int'(err), 1);
    corrupt = 1'b0;
    run_one(1, 1, 1, 5);
    check("t6_err_sticky", int'(err), 1);
    do_reset();
    check("t6_err_cleared", int'(err), 0);

    // Random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      reset_n = ($urandom_range(299) != 0);
      corrupt = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req_start[i*W +: W] = W'($urandom);
            req_len[i*W +: W]   = ($urandom_range(9) == 0) ? W'(M - 1) : W'($urandom_range(6));
            req[i] = 1'b1;
          end
        end else if (done[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          req_start[i*W +: W] = W'($urandom);
          req_len[i*W +: W]   = W'($urandom);
        end
      end
    end
    reset_n = 1'b1;
    req = '0;
    corrupt = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
